// File: rtl/live_trigger_gate.sv
// live_trigger_gate
// Gates raw trigger edges with the live window, emits a fixed-width trigger
// pulse followed by a dead-time holdoff, and keeps per-run saturating counters
// of live cycles, accepted triggers and vetoed triggers.
// Optional feature: define LIVE_TRIG_DEADTIME_CNT_EN to add the cnt_dead
// output, which counts cycles with busy high.
module live_trigger_gate #(
    parameter int TRIG_WIDTH = 4,
    parameter int HOLDOFF    = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_gate,
    input  logic             live_in,
    input  logic             trig_in,
    input  logic             clr_cnt,
    output logic             out_trig,
    output logic             busy,
    output logic             run_done,
    output logic [CNT_W-1:0] cnt_live,
    output logic [CNT_W-1:0] cnt_accept,
    output logic [CNT_W-1:0] cnt_veto_live,
`ifdef LIVE_TRIG_DEADTIME_CNT_EN
    output logic [CNT_W-1:0] cnt_veto_busy,
    output logic [CNT_W-1:0] cnt_dead
`else
    output logic [CNT_W-1:0] cnt_veto_busy
`endif
);

    // Timer only needs to span the longer of the pulse and the holdoff
    localparam int TMR_MAX = (TRIG_WIDTH > HOLDOFF) ? TRIG_WIDTH : HOLDOFF;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] FIRE_LAST = TMR_W'(TRIG_WIDTH - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FIRE    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q;
    logic             trig_d, ena_d;
    logic             trig_edge, run_start, busy_state;
    logic             out_trig_d, busy_d, run_done_d;
    logic             inc_live, inc_accept, inc_veto_live, inc_veto_busy;

    assign trig_edge  = trig_in & ~trig_d;
    assign run_start  = ena_gate & ~ena_d;
    assign busy_state = (state_q == ST_FIRE) || (state_q == ST_HOLDOFF);

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    // State register, phase timer, input history and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            trig_d   <= 1'b0;
            ena_d    <= 1'b0;
            out_trig <= 1'b0;
            busy     <= 1'b0;
            run_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Timer restarts on every state change and only runs in timed states
            tmr_q    <= ((state_d == state_q) && busy_state) ? tmr_q + TMR_W'(1) : '0;
            trig_d   <= trig_in;
            ena_d    <= ena_gate;
            out_trig <= out_trig_d;
            busy     <= busy_d;
            run_done <= run_done_d;
        end
    end

    // Next-state logic; dropping ena_gate aborts from any state
    always_comb begin
        state_d = state_q;
        if (!ena_gate) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_ARMED;
                ST_ARMED:   if (trig_edge && live_in) state_d = ST_FIRE;
                ST_FIRE:    if (tmr_q == FIRE_LAST)
                                state_d = (HOLDOFF == 0) ? ST_ARMED : ST_HOLDOFF;
                ST_HOLDOFF: if (tmr_q == HOLD_LAST) state_d = ST_ARMED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Output and counter-event decode from current and next state
    always_comb begin
        out_trig_d    = (state_d == ST_FIRE);
        busy_d        = (state_d == ST_FIRE) || (state_d == ST_HOLDOFF);
        run_done_d    = ena_d & ~ena_gate;
        inc_live      = ena_gate & live_in & (state_q != ST_IDLE);
        inc_accept    = ena_gate & trig_edge & live_in & (state_q == ST_ARMED);
        inc_veto_live = ena_gate & trig_edge & ~live_in & (state_q == ST_ARMED);
        inc_veto_busy = ena_gate & trig_edge & busy_state;
    end

    // Run counters: zeroed on reset, clear or run start; otherwise saturate
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt || run_start) begin
            cnt_live      <= '0;
            cnt_accept    <= '0;
            cnt_veto_live <= '0;
            cnt_veto_busy <= '0;
        end else begin
            cnt_live      <= sat_inc(cnt_live, inc_live);
            cnt_accept    <= sat_inc(cnt_accept, inc_accept);
            cnt_veto_live <= sat_inc(cnt_veto_live, inc_veto_live);
            cnt_veto_busy <= sat_inc(cnt_veto_busy, inc_veto_busy);
        end
    end

`ifdef LIVE_TRIG_DEADTIME_CNT_EN
    // Dead-time counter: one count per cycle the busy output is high
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt || run_start)
            cnt_dead <= '0;
        else
            cnt_dead <= sat_inc(cnt_dead, busy);
    end
`endif

endmodule

// File: tb/tb_live_trigger_gate.sv
// Bench for live_trigger_gate: reset, table of scripted vectors, directed
// multi-cycle corner sequences and randomized traffic against a model that
// tracks "remaining busy cycles" instead of an explicit state machine.
module tb_live_trigger_gate;

    localparam int TW = 4;
    localparam int HO = 16;
    localparam bit H  = 1'b1;
    localparam bit L  = 1'b0;

    logic        clk;
    logic        rst_n, ena_gate, live_in, trig_in, clr_cnt;
    logic        out_trig, busy, run_done;
    logic [31:0] cnt_live, cnt_accept, cnt_veto_live, cnt_veto_busy;
    logic        c4_out_trig, c4_busy, c4_run_done;
    logic [3:0]  c4_live, c4_accept, c4_veto_live, c4_veto_busy;
`ifdef LIVE_TRIG_DEADTIME_CNT_EN
    logic [31:0] cnt_dead;
    logic [3:0]  c4_dead;
`endif

    live_trigger_gate #(.TRIG_WIDTH(TW), .HOLDOFF(HO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ena_gate(ena_gate), .live_in(live_in),
        .trig_in(trig_in), .clr_cnt(clr_cnt), .out_trig(out_trig), .busy(busy),
        .run_done(run_done), .cnt_live(cnt_live), .cnt_accept(cnt_accept),
        .cnt_veto_live(cnt_veto_live),
`ifdef LIVE_TRIG_DEADTIME_CNT_EN
        .cnt_veto_busy(cnt_veto_busy), .cnt_dead(cnt_dead)
`else
        .cnt_veto_busy(cnt_veto_busy)
`endif
    );

    live_trigger_gate #(.TRIG_WIDTH(TW), .HOLDOFF(HO), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena_gate(ena_gate), .live_in(live_in),
        .trig_in(trig_in), .clr_cnt(clr_cnt), .out_trig(c4_out_trig), .busy(c4_busy),
        .run_done(c4_run_done), .cnt_live(c4_live), .cnt_accept(c4_accept),
        .cnt_veto_live(c4_veto_live),
`ifdef LIVE_TRIG_DEADTIME_CNT_EN
        .cnt_veto_busy(c4_veto_busy), .cnt_dead(c4_dead)
`else
        .cnt_veto_busy(c4_veto_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    longint m_live, m_acc, m_vl, m_vb, m_dead;
    int     m_rem;
    bit     m_out, m_busy, m_rd, m_trig_prev, m_ena_prev;

    typedef struct {
        bit ena, live, trig, clr;
        bit e_out, e_busy, e_rd;
        int e_acc, e_vl, e_vb, e_live;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic longint sat4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_update(input logic r, e, l, t, c);
        bit tedge, start, active, dinc;
        if (!r) begin
            m_live = 0; m_acc = 0; m_vl = 0; m_vb = 0; m_dead = 0; m_rem = 0;
            m_out = 0; m_busy = 0; m_rd = 0; m_trig_prev = 0; m_ena_prev = 0;
            return;
        end
        tedge  = t & ~m_trig_prev;
        start  = e & ~m_ena_prev;
        active = e & m_ena_prev;
        dinc   = m_busy;
        m_rd   = m_ena_prev & ~e;
        if (!active) begin
            m_rem = 0;
        end else begin
            if (l) m_live++;
            if (m_rem > 0) begin
                if (tedge) m_vb++;
                m_rem--;
            end else if (tedge) begin
                if (l) begin m_acc++; m_rem = TW + HO; end
                else m_vl++;
            end
        end
        if (dinc) m_dead++;
        if (c || start) begin
            m_live = 0; m_acc = 0; m_vl = 0; m_vb = 0; m_dead = 0;
        end
        m_out = (m_rem > HO);
        m_busy = (m_rem > 0);
        m_trig_prev = t;
        m_ena_prev = e;
    endtask

    task automatic compare_all();
        chk("out_trig", out_trig, m_out);
        chk("busy", busy, m_busy);
        chk("run_done", run_done, m_rd);
        chk("cnt_live", cnt_live, m_live);
        chk("cnt_accept", cnt_accept, m_acc);
        chk("cnt_veto_live", cnt_veto_live, m_vl);
        chk("cnt_veto_busy", cnt_veto_busy, m_vb);
        chk("c4_accept", c4_accept, sat4(m_acc));
        chk("c4_live", c4_live, sat4(m_live));
        chk("c4_veto_busy", c4_veto_busy, sat4(m_vb));
`ifdef LIVE_TRIG_DEADTIME_CNT_EN
        chk("cnt_dead", cnt_dead, m_dead);
        chk("c4_dead", c4_dead, sat4(m_dead));
`endif
    endtask

    task automatic step(input logic r, e, l, t, c);
        rst_n = r; ena_gate = e; live_in = l; trig_in = t; clr_cnt = c;
        @(posedge clk);
        model_update(r, e, l, t, c);
        #1;
        compare_all();
    endtask

    initial begin
        int  oc, bc;
        logic re, rl, rt, rc;

        tbl[0]  = '{H,H,L,L, L,L,L, 0,0,0,0};
        tbl[1]  = '{H,H,L,L, L,L,L, 0,0,0,1};
        tbl[2]  = '{H,L,H,L, L,L,L, 0,1,0,1};
        tbl[3]  = '{H,H,L,L, L,L,L, 0,1,0,2};
        tbl[4]  = '{H,H,H,L, H,H,L, 1,1,0,3};
        tbl[5]  = '{H,H,L,L, H,H,L, 1,1,0,4};
        tbl[6]  = '{H,H,H,L, H,H,L, 1,1,1,5};
        tbl[7]  = '{L,H,L,L, L,L,H, 1,1,1,5};
        tbl[8]  = '{L,H,L,L, L,L,L, 1,1,1,5};
        tbl[9]  = '{L,L,L,H, L,L,L, 0,0,0,0};
        tbl[10] = '{L,L,L,L, L,L,L, 0,0,0,0};

        // Reset held with trigger toggling: every output stays zero
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, i[0], 1'b0);
        chk("rst_out_trig", out_trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_run_done", run_done, 0);
        chk("rst_cnt_accept", cnt_accept, 0);
        chk("rst_cnt_live", cnt_live, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Scripted vectors with hand-derived expectations
        for (int i = 0; i < 11; i++) begin
            step(1'b1, tbl[i].ena, tbl[i].live, tbl[i].trig, tbl[i].clr);
            chk($sformatf("tbl%0d_out", i), out_trig, tbl[i].e_out);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_rd", i), run_done, tbl[i].e_rd);
            chk($sformatf("tbl%0d_acc", i), cnt_accept, tbl[i].e_acc);
            chk($sformatf("tbl%0d_vl", i), cnt_veto_live, tbl[i].e_vl);
            chk($sformatf("tbl%0d_vb", i), cnt_veto_busy, tbl[i].e_vb);
            chk($sformatf("tbl%0d_live", i), cnt_live, tbl[i].e_live);
        end

        // Accept: pulse width, busy length and one-cycle latency
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("latency_out", out_trig, 1);
        oc = int'(out_trig); bc = int'(busy);
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            oc += int'(out_trig); bc += int'(busy);
        end
        chk("pulse_width", oc, 4);
        chk("busy_len", bc, 20);
        chk("accept_one", cnt_accept, 1);
`ifdef LIVE_TRIG_DEADTIME_CNT_EN
        chk("dead_twenty", cnt_dead, 20);
`endif

        // Busy vetoes at +10 and in the last holdoff cycle; first armed cycle accepts
        for (int k = 0; k <= 43; k++)
            step(1'b1, 1'b1, 1'b1, (k == 0 || k == 10 || k == 20 || k == 22 || k == 43), 1'b0);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("seq_accept", cnt_accept, 4);
        chk("seq_veto_busy", cnt_veto_busy, 2);
        chk("seq_veto_live", cnt_veto_live, 0);

        // Live window 12-cycle period, 9 on, over 120 run cycles
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 120; i++) step(1'b1, 1'b1, ((i % 12) < 9), 1'b0, 1'b0);
        chk("live_ninety", cnt_live, 90);

        // Abort mid-FIRE, counters hold
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("abort_out", out_trig, 0);
        chk("abort_busy", busy, 0);
        chk("abort_run_done", run_done, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_rd_low", run_done, 0);
        chk("abort_acc_hold", cnt_accept, 1);
        chk("abort_live_hold", cnt_live, 92);

        // clr_cnt coincident with an accept
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_accept", cnt_accept, 0);
        chk("clr_pulse", out_trig, 1);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Saturation: 20 accepts on the 4-bit instance
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 21; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_accept32", cnt_accept, 20);
        chk("sat_accept4", c4_accept, 15);

        // Reset asserted mid-pulse
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_out", out_trig, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_acc", cnt_accept, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            re = ($urandom_range(0, 63) != 0);
            rl = 1'($urandom_range(0, 1));
            rt = ($urandom_range(0, 2) == 0) ? ~trig_in : trig_in;
            rc = ($urandom_range(0, 99) == 0);
            step(1'b1, re, rl, rt, rc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
